fpu_wb_buffer: RTL and testbench

FPU_WB_BUFFER -- requirements
Module: fpu_wb_buffer

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_fifo.sv | 54 +++++
 rtl/fpu_wb_buffer.sv | 107 ++++++++++
 tb/tb_fpu_wb_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared widths, writeback source encodings and the queued entry layout for the
// converter writeback buffer.
package fpu_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_IDX_W  = 5;
  localparam logic        WB_SRC_INT = 1'b0;
  localparam logic        WB_SRC_FLT = 1'b1;

  typedef struct packed {
    logic [WORD_W-1:0]    data;
    logic [REG_IDX_W-1:0] rd;
  } wb_entry_t;

endpackage

// File: rtl/fpu_fifo.sv
// Circular FIFO with registered storage; full/empty/count derive from registered state
// only, so the head is visible one cycle after a push.
module fpu_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_wb_buffer.sv
// Merges float-to-int and int-to-float converter results into a single register-file
// writeback port with per-channel queues and a stall-locked round-robin grant.
module fpu_wb_buffer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ftoi_valid,
  input  logic [WORD_W-1:0]    ftoi_data,
  input  logic [REG_IDX_W-1:0] ftoi_rd,
  output logic                 ftoi_ready,
  input  logic                 itof_valid,
  input  logic [WORD_W-1:0]    itof_data,
  input  logic [REG_IDX_W-1:0] itof_rd,
  output logic                 itof_ready,
  output logic                 wb_valid,
  output logic [WORD_W-1:0]    wb_data,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_src,
  input  logic                 wb_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wb_entry_t       ftoi_head, itof_head, wb_head;
  logic            ftoi_full, ftoi_empty, itof_full, itof_empty;
  logic [CntW-1:0] ftoi_count, itof_count;
  logic            wb_fire, grant_flt;
  logic            grant_q, last_q, lock_q;

  assign ftoi_ready = !ftoi_full;
  assign itof_ready = !itof_full;

  fpu_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(wb_entry_t))
  ) u_ftoi_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (ftoi_valid && ftoi_ready),
    .wdata({ftoi_data, ftoi_rd}),
    .pop  (wb_fire && (grant_flt == WB_SRC_INT)),
    .rdata(ftoi_head),
    .full (ftoi_full),
    .empty(ftoi_empty),
    .count(ftoi_count)
  );

  fpu_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(wb_entry_t))
  ) u_itof_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (itof_valid && itof_ready),
    .wdata({itof_data, itof_rd}),
    .pop  (wb_fire && (grant_flt == WB_SRC_FLT)),
    .rdata(itof_head),
    .full (itof_full),
    .empty(itof_empty),
    .count(itof_count)
  );

  assign wb_valid = (ftoi_count != '0) || (itof_count != '0);
  assign wb_fire  = wb_valid && wb_ready;

  // A stalled request keeps its grant; queue heads cannot change until it completes.
  always_comb begin
    grant_flt = WB_SRC_INT;
    if (lock_q) begin
      grant_flt = grant_q;
    end else if (!ftoi_empty && !itof_empty) begin
      grant_flt = ~last_q;
    end else if (!itof_empty) begin
      grant_flt = WB_SRC_FLT;
    end
  end

  // last_q resets to the float side so the int channel wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q  <= WB_SRC_FLT;
      lock_q  <= 1'b0;
      grant_q <= WB_SRC_INT;
    end else begin
      lock_q  <= wb_valid && !wb_ready;
      grant_q <= grant_flt;
      if (wb_fire) last_q <= grant_flt;
    end
  end

  assign wb_head = (grant_flt == WB_SRC_FLT) ? itof_head : ftoi_head;

  always_comb begin
    wb_data = '0;
    wb_rd   = '0;
    wb_src  = WB_SRC_INT;
    if (wb_valid) begin
      wb_data = wb_head.data;
      wb_rd   = wb_head.rd;
      wb_src  = grant_flt;
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Scoreboard bench for fpu_wb_buffer: the driver queues accepted entries per channel and
// a monitor predicts the round-robin writeback from those queues every cycle.
module tb_fpu_wb_buffer;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ftoi_valid, itof_valid, wb_ready;
  logic [31:0] ftoi_data, itof_data;
  logic [4:0]  ftoi_rd, itof_rd;
  logic        ftoi_ready, itof_ready, wb_valid, wb_src;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  fpu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ftoi_valid(ftoi_valid),
    .ftoi_data (ftoi_data),
    .ftoi_rd   (ftoi_rd),
    .ftoi_ready(ftoi_ready),
    .itof_valid(itof_valid),
    .itof_data (itof_data),
    .itof_rd   (itof_rd),
    .itof_ready(itof_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_src    (wb_src),
    .wb_ready  (wb_ready)
  );

  int   checks = 0;
  int   errors = 0;
  ent_t fq[$];
  ent_t iq[$];
  bit   last_flt = 1'b1;  // last grant went to float side, so int channel is preferred
  bit   stalled  = 1'b0;
  bit   prev_g   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit fv, input logic [31:0] fd, input logic [4:0] frd,
                       input bit iv, input logic [31:0] idt, input logic [4:0] ird,
                       input bit wr);
    bit fr, ir;
    @(negedge clk);
    ftoi_valid = fv; ftoi_data = fd;  ftoi_rd = frd;
    itof_valid = iv; itof_data = idt; itof_rd = ird;
    wb_ready   = wr;
    fr = ftoi_ready;
    ir = itof_ready;
    @(posedge clk);
    if (fv && fr) fq.push_back('{fd, frd});
    if (iv && ir) iq.push_back('{idt, ird});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb_valid"}, wb_valid, 0);
    check({tag, "_wb_data"}, wb_data, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
    check({tag, "_wb_src"}, wb_src, 0);
    check({tag, "_ftoi_ready"}, ftoi_ready, 1);
    check({tag, "_itof_ready"}, itof_ready, 1);
  endtask

  // Reset lands between clock edges to exercise the asynchronous clear.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3;
    rstn = 1'b0;
    ftoi_valid = 1'b0; itof_valid = 1'b0; wb_ready = 1'b0;
    #1;
    check_reset_outputs(tag);
    fq.delete();
    iq.delete();
    last_flt = 1'b1;
    stalled  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: predicts every cycle's writeback from the model queues.
  bit   exp_v, g;
  ent_t e;
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        exp_v = (fq.size() != 0) || (iq.size() != 0);
        check("ftoi_ready", ftoi_ready, fq.size() < DEPTH);
        check("itof_ready", itof_ready, iq.size() < DEPTH);
        check("wb_valid", wb_valid, exp_v);
        if (exp_v) begin
          if (stalled) g = prev_g;
          else if (fq.size() != 0 && iq.size() != 0) g = !last_flt;
          else g = (iq.size() != 0);
          if (g) e = iq[0];
          else e = fq[0];
          check("wb_src", wb_src, g);
          check("wb_data", wb_data, e.data);
          check("wb_rd", wb_rd, e.rd);
          if (wb_ready) begin
            if (g) e = iq.pop_front();
            else e = fq.pop_front();
            last_flt = g;
            stalled  = 1'b0;
          end else begin
            stalled = 1'b1;
            prev_g  = g;
          end
        end else begin
          check("idle_wb_data", wb_data, 0);
          check("idle_wb_rd", wb_rd, 0);
          check("idle_wb_src", wb_src, 0);
          stalled = 1'b0;
        end
      end
    end
  end

  logic [31:0] hold_data;
  logic [4:0]  hold_rd;
  logic        hold_src;
  logic        srcs[6];
  int          n_src;

  initial begin
    ftoi_valid = 0; ftoi_data = 0; ftoi_rd = 0;
    itof_valid = 0; itof_data = 0; itof_rd = 0;
    wb_ready   = 0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #6;
    check_reset_outputs("por");
    @(negedge clk);
    rstn = 1'b1;

    // Single int-channel entry appears one cycle after the push.
    drive(1, 32'h0000_0003, 5'd5, 0, 0, 0, 1);
    #1;
    check("single_valid", wb_valid, 1);
    check("single_data", wb_data, 32'h3);
    check("single_rd", wb_rd, 5);
    check("single_src", wb_src, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("single_drained", wb_valid, 0);

    // Both channels streaming: grants alternate starting with the int channel.
    do_reset("rst_alt");
    n_src = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, $urandom, 5'(k), 1, $urandom, 5'(k + 8), 1);
      #1;
      if (wb_valid && n_src < 6) begin
        srcs[n_src] = wb_src;
        n_src++;
      end
    end
    check("alt_samples", n_src, 6);
    for (int k = 0; k < 6; k++) check("alt_src", srcs[k], k % 2);

    // Stall: outputs frozen, queues fill and readies drop.
    do_reset("rst_stall");
    drive(1, 32'hA000_0001, 5'd1, 1, 32'hB000_0002, 5'd2, 0);
    #1;
    hold_data = wb_data; hold_rd = wb_rd; hold_src = wb_src;
    check("stall_first_data", hold_data, 32'hA000_0001);
    check("stall_first_src", hold_src, 0);
    drive(1, 32'hC000_0003, 5'd3, 1, 32'hD000_0004, 5'd4, 0);
    #1;
    check("stall_ftoi_full", ftoi_ready, 0);
    check("stall_itof_full", itof_ready, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("stall_hold_data", wb_data, hold_data);
      check("stall_hold_rd", wb_rd, hold_rd);
      check("stall_hold_src", wb_src, hold_src);
    end

    // Push into a full int channel while it dequeues: refused this cycle only.
    @(negedge clk);
    ftoi_valid = 1; ftoi_data = 32'hDEAD_BEEF; ftoi_rd = 5'd9;
    itof_valid = 0; wb_ready = 1;
    #1;
    check("full_deq_ready_low", ftoi_ready, 0);
    @(posedge clk);
    ftoi_valid = 0;
    #1;
    check("full_deq_ready_back", ftoi_ready, 1);
    check("full_deq_next_src", wb_src, 1);
    check("full_deq_next_data", wb_data, 32'hB000_0002);

    // Reset with two entries per queue discards everything.
    drive(1, 32'hE000_0005, 5'd7, 0, 0, 0, 0);
    check("pre_rst_fq", fq.size(), 2);
    check("pre_rst_iq", iq.size(), 2);
    do_reset("rst_mid");
    drive(0, 0, 0, 1, 32'h3F80_0000, 5'd1, 1);
    #1;
    check("post_rst_valid", wb_valid, 1);
    check("post_rst_src", wb_src, 1);
    check("post_rst_data", wb_data, 32'h3F80_0000);
    check("post_rst_rd", wb_rd, 1);

    // Randomised traffic with random back-pressure.
    do_reset("rst_rand");
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    check("drained_model", fq.size() + iq.size(), 0);
    check("drained_wb_valid", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
